// File: rtl/idma_lite_req_arbiter.sv
// Round-robin request arbiter that lets NumChan channels share one iDMA backend.
// Responses return to their channels in issue order through a small routing FIFO of grant indices.
module idma_lite_req_arbiter #(
  parameter int NumChan        = 4,
  parameter int ReqWidth       = 128,
  parameter int RspWidth       = 40,
  parameter int MaxOutstanding = 4,
  localparam int CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumChan-1:0]          ch_req_valid_i,
  output logic [NumChan-1:0]          ch_req_ready_o,
  input  logic [NumChan*ReqWidth-1:0] ch_req_i,
  output logic                        be_req_valid_o,
  input  logic                        be_req_ready_i,
  output logic [ReqWidth-1:0]         be_req_o,
  input  logic                        be_rsp_valid_i,
  output logic                        be_rsp_ready_o,
  input  logic [RspWidth-1:0]         be_rsp_i,
  output logic [NumChan-1:0]          ch_rsp_valid_o,
  input  logic [NumChan-1:0]          ch_rsp_ready_i,
  output logic [RspWidth-1:0]         ch_rsp_o,
  output logic [CntWidth-1:0]         outstanding_o,
  output logic                        busy_o
);

  localparam int IdxW = $clog2(NumChan);
  localparam int PtrW = $clog2(MaxOutstanding);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e              state_q;
  logic [IdxW-1:0]     lock_idx_q;
  logic [IdxW-1:0]     rr_ptr_q;

  logic [IdxW-1:0]     fifo_mem_q [MaxOutstanding];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] count_q;

  logic [IdxW-1:0]     grant;
  logic                grant_valid;
  logic [IdxW:0]       rr_sum;
  logic                fifo_full, fifo_empty;
  logic [IdxW-1:0]     head;
  logic                req_hs, rsp_hs;

  assign fifo_full  = (count_q == CntWidth'(MaxOutstanding));
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_mem_q[rd_ptr_q];

  // A held lock overrides the round-robin search so the presented payload stays stable.
  always_comb begin
    grant       = lock_idx_q;
    grant_valid = 1'b0;
    rr_sum      = '0;
    if (state_q == LOCKED) begin
      grant_valid = 1'b1;
    end else begin
      for (int i = 0; i < NumChan; i++) begin
        rr_sum = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
        if (rr_sum >= (IdxW+1)'(NumChan)) rr_sum = rr_sum - (IdxW+1)'(NumChan);
        if (!grant_valid && ch_req_valid_i[rr_sum[IdxW-1:0]]) begin
          grant       = rr_sum[IdxW-1:0];
          grant_valid = 1'b1;
        end
      end
    end
  end

  // Gating with rst_i keeps every handshake output low for the whole reset pulse.
  assign be_req_valid_o = grant_valid && !fifo_full && !rst_i;
  assign be_req_o       = ch_req_i[grant*ReqWidth +: ReqWidth];
  assign req_hs         = be_req_valid_o && be_req_ready_i;

  always_comb begin
    ch_req_ready_o        = '0;
    ch_req_ready_o[grant] = req_hs;
  end

  assign be_rsp_ready_o = ch_rsp_ready_i[head] && !fifo_empty;
  assign rsp_hs         = be_rsp_valid_i && be_rsp_ready_o;
  assign ch_rsp_o       = be_rsp_i;

  always_comb begin
    ch_rsp_valid_o       = '0;
    ch_rsp_valid_o[head] = be_rsp_valid_i && !fifo_empty;
  end

  assign outstanding_o = count_q;
  assign busy_o        = (count_q != '0) || be_req_valid_o;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (be_req_valid_o && !be_req_ready_i) begin
          state_q    <= LOCKED;
          lock_idx_q <= grant;
        end
        LOCKED: if (be_req_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (req_hs) rr_ptr_q <= (grant == IdxW'(NumChan - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (req_hs) wr_ptr_q <= (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (rsp_hs) rd_ptr_q <= (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({req_hs, rsp_hs})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: routing storage has no reset; entries are only read while count_q says they are valid.
  always_ff @(posedge clk_i) begin
    if (req_hs) fifo_mem_q[wr_ptr_q] <= grant;
  end

endmodule

// File: tb/tb_idma_lite_req_arbiter.sv
// Randomized bench for idma_lite_req_arbiter, checked each cycle against a queue-based model
// built from the arbitration and in-order response routing rules.
module tb_idma_lite_req_arbiter;

  localparam int N  = 4;
  localparam int RW = 128;
  localparam int SW = 40;
  localparam int MO = 4;
  localparam int CW = $clog2(MO + 1);

  logic            clk = 1'b0;
  logic            rst_i;
  logic [N-1:0]    ch_req_valid_i, ch_req_ready_o;
  logic [N*RW-1:0] ch_req_i;
  logic            be_req_valid_o, be_req_ready_i;
  logic [RW-1:0]   be_req_o;
  logic            be_rsp_valid_i, be_rsp_ready_o;
  logic [SW-1:0]   be_rsp_i;
  logic [N-1:0]    ch_rsp_valid_o, ch_rsp_ready_i;
  logic [SW-1:0]   ch_rsp_o;
  logic [CW-1:0]   outstanding_o;
  logic            busy_o;

  idma_lite_req_arbiter #(
    .NumChan(N), .ReqWidth(RW), .RspWidth(SW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ch_req_valid_i(ch_req_valid_i), .ch_req_ready_o(ch_req_ready_o), .ch_req_i(ch_req_i),
    .be_req_valid_o(be_req_valid_o), .be_req_ready_i(be_req_ready_i), .be_req_o(be_req_o),
    .be_rsp_valid_i(be_rsp_valid_i), .be_rsp_ready_o(be_rsp_ready_o), .be_rsp_i(be_rsp_i),
    .ch_rsp_valid_o(ch_rsp_valid_o), .ch_rsp_ready_i(ch_rsp_ready_i), .ch_rsp_o(ch_rsp_o),
    .outstanding_o(outstanding_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: next channel to serve, a pending (unaccepted) grant, and issued channels in order.
  int m_rr;
  int m_lock;
  int m_q[$];

  task automatic model_reset();
    m_rr   = 0;
    m_lock = -1;
    m_q.delete();
  endtask

  function automatic int model_grant();
    if (m_lock >= 0) return m_lock;
    for (int i = 0; i < N; i++)
      if (ch_req_valid_i[(m_rr + i) % N]) return (m_rr + i) % N;
    return -1;
  endfunction

  task automatic cycle(input int p_req, input int p_bready, input int p_rsp, input int p_cready);
    int         g;
    logic       e_bvalid, e_rready;
    logic [N-1:0] e_creq, e_crsp;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      ch_req_valid_i[k] = ($urandom_range(99) < p_req);
      ch_rsp_ready_i[k] = ($urandom_range(99) < p_cready);
    end
    if (m_lock >= 0) ch_req_valid_i[m_lock] = 1'b1;
    for (int j = 0; j < N*RW/32; j++) ch_req_i[j*32 +: 32] = $urandom();
    be_req_ready_i = ($urandom_range(99) < p_bready);
    be_rsp_valid_i = ($urandom_range(99) < p_rsp);
    be_rsp_i       = SW'({$urandom(), $urandom()});
    #1;
    g        = model_grant();
    e_bvalid = (g >= 0) && (m_q.size() < MO);
    e_creq   = '0;
    if (e_bvalid && be_req_ready_i) e_creq[g] = 1'b1;
    e_crsp   = '0;
    e_rready = 1'b0;
    if (m_q.size() > 0) begin
      e_crsp[m_q[0]] = be_rsp_valid_i;
      e_rready       = ch_rsp_ready_i[m_q[0]];
    end
    check("be_req_valid", 128'(be_req_valid_o), 128'(e_bvalid));
    if (e_bvalid) check("be_req_data", be_req_o, ch_req_i[g*RW +: RW]);
    check("ch_req_ready", 128'(ch_req_ready_o), 128'(e_creq));
    check("ch_rsp_valid", 128'(ch_rsp_valid_o), 128'(e_crsp));
    check("be_rsp_ready", 128'(be_rsp_ready_o), 128'(e_rready));
    check("outstanding", 128'(outstanding_o), 128'(m_q.size()));
    check("busy", 128'(busy_o), 128'((m_q.size() != 0) || e_bvalid));
    if (be_rsp_valid_i) check("ch_rsp_data", 128'(ch_rsp_o), 128'(be_rsp_i));
    @(posedge clk);
    if (be_rsp_valid_i && e_rready) void'(m_q.pop_front());
    if (e_bvalid && be_req_ready_i) begin
      m_q.push_back(g);
      m_rr   = (g + 1) % N;
      m_lock = -1;
    end else if (e_bvalid) begin
      m_lock = g;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_outstanding"}, 128'(outstanding_o), 128'(0));
    check({tag, "_busy"}, 128'(busy_o), 128'(0));
    check({tag, "_be_req_valid"}, 128'(be_req_valid_o), 128'(0));
    check({tag, "_ch_req_ready"}, 128'(ch_req_ready_o), 128'(0));
    check({tag, "_be_rsp_ready"}, 128'(be_rsp_ready_o), 128'(0));
    check({tag, "_ch_rsp_valid"}, 128'(ch_rsp_valid_o), 128'(0));
  endtask

  initial begin
    rst_i          = 1'b1;
    ch_req_valid_i = '1;
    ch_req_i       = '0;
    be_req_ready_i = 1'b1;
    be_rsp_valid_i = 1'b1;
    be_rsp_i       = '0;
    ch_rsp_ready_i = '1;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("por");
    ch_req_valid_i = '0;
    be_req_ready_i = 1'b0;
    be_rsp_valid_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;

    repeat (40)  cycle(100, 100, 0, 100);
    repeat (300) cycle(60, 70, 60, 80);
    repeat (60)  cycle(90, 30, 20, 50);
    repeat (30)  cycle(80, 100, 0, 100);

    @(negedge clk);
    rst_i          = 1'b1;
    ch_req_valid_i = '1;
    be_req_ready_i = 1'b1;
    be_rsp_valid_i = 1'b1;
    ch_rsp_ready_i = '1;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    ch_req_valid_i = '0;
    be_req_ready_i = 1'b0;
    be_rsp_valid_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;

    repeat (5)   cycle(0, 0, 100, 100);
    repeat (300) cycle(50, 60, 50, 70);
    repeat (50)  cycle(20, 50, 90, 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/idma_lite_req_arbiter.md
IDMA_LITE_REQ_ARBITER -- requirements
Module: idma_lite_req_arbiter

Interface
REQ-001 SHALL have parameter NumChan, default 4: number of requesting channels sharing one backend; legal range 2..16.
REQ-002 SHALL have parameter ReqWidth, default 128: width of the flattened 1D request payload.
REQ-003 SHALL have parameter RspWidth, default 40: width of the flattened response payload.
REQ-004 SHALL have parameter MaxOutstanding, default 4: depth of the response-routing FIFO; legal range 2..16.
REQ-005 SHALL have parameter CntWidth = $clog2(MaxOutstanding+1), derived and not overridden.
REQ-006 clk_i  in  1  single clock; all logic on the rising edge.
REQ-007 rst_i  in  1  reset, asynchronous and active-high.
REQ-008 ch_req_valid_i  in  NumChan  per-channel request valid.
REQ-009 ch_req_ready_o  out  NumChan  per-channel request ready.
REQ-010 ch_req_i  in  NumChan*ReqWidth  per-channel payload; channel k occupies bits [k*ReqWidth +: ReqWidth].
REQ-011 be_req_valid_o / be_req_ready_i / be_req_o  out/in/out  1/1/ReqWidth  request port toward the backend.
REQ-012 be_rsp_valid_i / be_rsp_ready_o / be_rsp_i  in/out/in  1/1/RspWidth  response port from the backend.
REQ-013 ch_rsp_valid_o / ch_rsp_ready_i  out/in  NumChan/NumChan  per-channel response handshake.
REQ-014 ch_rsp_o  out  RspWidth  response payload, broadcast to all channels.
REQ-015 outstanding_o  out  CntWidth  number of issued, unanswered requests.
REQ-016 busy_o  out  1  high when outstanding_o != 0 or be_req_valid_o is high.

Function
REQ-017 Arbitration SHALL be round-robin: with no lock held, grant the first valid channel at or after rr_ptr, ascending with wrap.
REQ-018 be_req_valid_o SHALL be high iff a channel is granted and the FIFO is not full; be_req_o SHALL equal the granted channel's payload.
REQ-019 ch_req_ready_o[k] SHALL equal be_req_ready_i AND be_req_valid_o AND (grant == k); all other bits SHALL be 0.
REQ-020 Lock: once be_req_valid_o is high without be_req_ready_i, the grant SHALL be held until the handshake completes, even if higher-priority channels raise valid.
REQ-021 On a request handshake, rr_ptr SHALL become (grant+1) mod NumChan and the grant index SHALL be pushed into the FIFO.
REQ-022 When the FIFO is full, be_req_valid_o SHALL be 0, no grant lock SHALL form, and rr_ptr SHALL NOT change. Full is registered, so a pop in the same cycle SHALL NOT permit a push.
REQ-023 Responses SHALL be routed in issue order: ch_rsp_valid_o[head] = be_rsp_valid_i AND FIFO not empty; be_rsp_ready_o = ch_rsp_ready_i[head] AND FIFO not empty.
REQ-024 With the FIFO empty, be_rsp_ready_o and all ch_rsp_valid_o SHALL be 0. A spurious be_rsp_valid_i is back-pressured, never dropped or misrouted.
REQ-025 On a response handshake, the FIFO head SHALL be popped.
REQ-026 Simultaneous push and pop SHALL leave outstanding_o unchanged. Otherwise outstanding_o increments by 1 on a push and decrements by 1 on a pop, never wrapping.
REQ-027 ch_rsp_o SHALL be a combinational pass-through of be_rsp_i (zero latency). The request path SHALL also be combinational (zero added latency).
REQ-028 Grant state SHALL be a 2-state FSM: IDLE (no lock) and LOCKED (valid presented, not accepted). IDLE->LOCKED on valid & !ready; LOCKED->IDLE on handshake.

Reset
REQ-029 While rst_i is high: rr_ptr=0, FSM=IDLE, FIFO empty, outstanding_o=0, all valid/ready outputs 0, busy_o=0.
REQ-030 Reset asserted mid-operation SHALL discard in-flight grants and routing entries immediately; no response SHALL be delivered for pre-reset requests.
REQ-031 Payload outputs are don't-care while their valid is 0.

Verification
REQ-032 Channels 0..3 all valid, be_req_ready_i=1, responses returned immediately -> grants in order 0,1,2,3,0; each ch_rsp_valid_o pulses on the matching channel.
REQ-033 Ch2 valid, be_req_ready_i=0 for 3 cycles, ch0 raises valid in cycle 2 -> be_req_o holds ch2 payload; ch2 accepted in cycle 4; ch0 granted next.
REQ-034 MaxOutstanding=4, 4 accepted requests, no response -> be_req_valid_o=0 and outstanding_o=4; one response pops -> next cycle a request issues.
REQ-035 Issue order ch3, ch1, ch3; return 3 responses with ch_rsp_ready_i=all-1 -> ch_rsp_valid_o = 4'b1000, 4'b0010, 4'b1000.
REQ-036 Response stall: head=ch1, ch_rsp_ready_i[1]=0 -> be_rsp_ready_o=0 and outstanding_o unchanged; ready=1 -> pop.
REQ-037 rst_i pulse with outstanding_o=3 -> outstanding_o=0 and busy_o=0 the same cycle; a following be_rsp_valid_i=1 -> be_rsp_ready_o=0.
